team_08_wb_initiator: RTL and testbench



---
 rtl/team_08_wb_initiator_if.sv | 44 ++++
 rtl/team_08_wb_initiator.sv | 101 ++++++++++
 tb/tb_team_08_wb_initiator.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/team_08_wb_initiator_if.sv
// Request/response and Wishbone signal bundle for team_08_wb_initiator.
// master: the initiator block itself; slave: the surrounding team logic and bus slave.
interface team_08_wb_initiator_if;
  // Valid/ready rule (both channels): a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, and the payload
  // is held stable while valid is high and ready is low.
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic [3:0]  req_sel_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;

  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        ack_i;
  logic        err_i;
  logic [31:0] dat_i;

  logic        busy_o;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
    input  rsp_ready_i, ack_i, err_i, dat_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, busy_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
    output rsp_ready_i, ack_i, err_i, dat_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, busy_o
  );
endinterface

// File: rtl/team_08_wb_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator: one request in, one bus cycle, one response out.
// Optional bus-cycle timeout is compiled in with TEAM_08_WB_INIT_TIMEOUT_EN.
module team_08_wb_initiator #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  team_08_wb_initiator_if.master bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // The counter must be able to represent TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  logic to_hit;

`ifdef TEAM_08_WB_INIT_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Sits at zero outside BUS, so it is already clear on the first BUS cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != BUS) begin
      to_cnt <= '0;
    end else if (!(bus.ack_i || bus.err_i)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  assign bus.req_ready_o = (state == IDLE);
  assign bus.busy_o      = (state != IDLE);
  assign dbg_state_o     = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      bus.cyc_o       <= 1'b0;
      bus.stb_o       <= 1'b0;
      bus.we_o        <= 1'b0;
      bus.adr_o       <= 32'h0;
      bus.dat_o       <= 32'h0;
      bus.sel_o       <= 4'h0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_dat_o   <= 32'h0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.we_o  <= bus.req_we_i;
            bus.adr_o <= bus.req_adr_i;
            bus.dat_o <= bus.req_dat_i;
            bus.sel_o <= bus.req_sel_i;
            bus.cyc_o <= 1'b1;
            bus.stb_o <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          if (bus.ack_i || bus.err_i || to_hit) begin
            bus.cyc_o       <= 1'b0;
            bus.stb_o       <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            state           <= RESP;
            // err_i beats ack_i; a timeout only fires when neither is present.
            if (bus.err_i || !bus.ack_i) begin
              bus.rsp_err_o <= 1'b1;
              bus.rsp_dat_o <= 32'h0;
            end else begin
              bus.rsp_err_o <= 1'b0;
              bus.rsp_dat_o <= bus.we_o ? 32'h0 : bus.dat_i;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_08_wb_initiator.sv
// Self-checking bench for team_08_wb_initiator: directed cases plus randomized transactions
// against a transaction-level model; honours TEAM_08_WB_INIT_TIMEOUT_EN when defined.
module tb_team_08_wb_initiator;

  localparam int TO_CYC = 8;
  localparam int TO_W   = 4;
`ifdef TEAM_08_WB_INIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  team_08_wb_initiator_if bus ();

  team_08_wb_initiator #(
    .TIMEOUT_CYCLES(TO_CYC),
    .TO_W          (TO_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic chk_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase 0 = waiting for a request, 1 = bus cycle open, 2 = response offered.
  int          cyc_n   = 0;
  int          m_phase = 0;
  int          m_start = 0;
  logic        m_fresh = 1'b1;
  logic        m_we    = 1'b0;
  logic [31:0] m_adr   = 32'h0;
  logic [31:0] m_dat   = 32'h0;
  logic [3:0]  m_sel   = 4'h0;
  logic [31:0] m_rsp_dat = 32'h0;
  logic        m_rsp_err = 1'b0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rst) begin
      m_phase   <= 0;
      m_fresh   <= 1'b1;
      m_we      <= 1'b0;
      m_adr     <= 32'h0;
      m_dat     <= 32'h0;
      m_sel     <= 4'h0;
      m_rsp_dat <= 32'h0;
      m_rsp_err <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.req_valid_i) begin
        m_phase <= 1;
        m_start <= cyc_n;
        m_fresh <= 1'b0;
        m_we    <= bus.req_we_i;
        m_adr   <= bus.req_adr_i;
        m_dat   <= bus.req_dat_i;
        m_sel   <= bus.req_sel_i;
      end
    end else if (m_phase == 1) begin
      // Bus cycles elapsed since acceptance reaching TO_CYC is a timeout.
      if (bus.ack_i || bus.err_i || (TO_EN && (cyc_n - m_start == TO_CYC))) begin
        m_phase   <= 2;
        m_rsp_err <= !(bus.ack_i && !bus.err_i);
        m_rsp_dat <= (bus.ack_i && !bus.err_i && !m_we) ? bus.dat_i : 32'h0;
      end
    end else if (bus.rsp_ready_i) begin
      m_phase <= 0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [32:0] exp_q[$];
  int          cyc_run      = 0;
  int          last_cyc_len = 0;
  int          rsp_run      = 0;
  int          last_rsp_len = 0;
  int          rsp_count    = 0;
  logic        last_we      = 1'b0;
  logic [31:0] last_adr     = 32'h0;
  logic [31:0] last_dat     = 32'h0;
  logic [3:0]  last_sel     = 4'h0;
  logic [31:0] last_rsp_dat = 32'h0;
  logic        last_rsp_err = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_o", bus.cyc_o, m_phase == 1);
      check("stb_o", bus.stb_o, m_phase == 1);
      check("req_ready_o", bus.req_ready_o, m_phase == 0);
      check("busy_o", bus.busy_o, m_phase != 0);
      check("rsp_valid_o", bus.rsp_valid_o, m_phase == 2);
      if (m_phase == 1 || m_fresh) begin
        check("we_o", bus.we_o, m_we);
        check("adr_o", bus.adr_o, m_adr);
        check("dat_o", bus.dat_o, m_dat);
        check("sel_o", bus.sel_o, m_sel);
      end
      if (m_phase == 2 || m_fresh) begin
        check("rsp_dat_o", bus.rsp_dat_o, m_rsp_dat);
        check("rsp_err_o", bus.rsp_err_o, m_rsp_err);
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        rsp_count    <= rsp_count + 1;
        last_rsp_dat <= bus.rsp_dat_o;
        last_rsp_err <= bus.rsp_err_o;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1'b1, 1'b0);
        end else begin
          check("sb_rsp", {bus.rsp_err_o, bus.rsp_dat_o}, exp_q[0]);
          exp_q.delete(0);
        end
      end
    end
    cyc_run <= bus.cyc_o ? cyc_run + 1 : 0;
    if (!bus.cyc_o && cyc_run != 0) last_cyc_len <= cyc_run;
    if (bus.cyc_o) begin
      last_we  <= bus.we_o;
      last_adr <= bus.adr_o;
      last_dat <= bus.dat_o;
      last_sel <= bus.sel_o;
    end
    rsp_run <= bus.rsp_valid_o ? rsp_run + 1 : 0;
    if (!bus.rsp_valid_o && rsp_run != 0) last_rsp_len <= rsp_run;
  end

  // ---------------- driver tasks (entered and left at posedge + #1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int guard;
    guard = 0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_adr_i   = adr;
    bus.req_dat_i   = dat;
    bus.req_sel_i   = sel;
    while (!bus.req_ready_o && guard < 20) begin
      idle(1);
      guard++;
    end
    check("req_ready_before_issue", bus.req_ready_o, 1'b1);
    idle(1);
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'($urandom_range(0, 1));
    bus.req_adr_i   = $urandom;
    bus.req_dat_i   = $urandom;
    bus.req_sel_i   = 4'($urandom_range(0, 15));
  endtask

  // Response side: backpressure for d cycles with stray ack/err, then one handshake.
  task automatic take_rsp(input int d);
    repeat (d) begin
      bus.ack_i = 1'($urandom_range(0, 1));
      bus.err_i = 1'($urandom_range(0, 1));
      idle(1);
    end
    bus.ack_i       = 1'b0;
    bus.err_i       = 1'b0;
    bus.rsp_ready_i = 1'b1;
    idle(1);
    bus.rsp_ready_i = 1'b0;
  endtask

  // mode 0: ack, 1: err, 2: ack and err together.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int waits, input int mode,
                         input int rsp_delay, input logic [31:0] rdata);
    issue(we, adr, dat, sel);
    repeat (waits) begin
      bus.dat_i = $urandom;
      idle(1);
    end
    bus.ack_i = (mode != 1);
    bus.err_i = (mode != 0);
    bus.dat_i = rdata;
    idle(1);
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    bus.dat_i = $urandom;
    exp_q.push_back((mode != 0) ? {1'b1, 32'h0} : {1'b0, (we ? 32'h0 : rdata)});
    take_rsp(rsp_delay);
  endtask

  task automatic run_hang(input logic [31:0] adr, input logic [31:0] late_data);
    int n;
    n = 0;
    issue(1'b0, adr, 32'h0, 4'hF);
    while (bus.cyc_o && n < 1000) begin
      idle(1);
      n++;
    end
    if (TO_EN) begin
      check("timeout_bus_cycles", n, TO_CYC);
      exp_q.push_back({1'b1, 32'h0});
      take_rsp(2);
      idle(1);
      check("timeout_cyc_len", last_cyc_len, 8);
      check("timeout_rsp_err", last_rsp_err, 1'b1);
      check("timeout_rsp_dat", last_rsp_dat, 32'h0);
    end else begin
      check("no_timeout_cyc_held", bus.cyc_o, 1'b1);
      check("no_timeout_cycles", n, 1000);
      bus.ack_i = 1'b1;
      bus.dat_i = late_data;
      idle(1);
      bus.ack_i = 1'b0;
      exp_q.push_back({1'b0, late_data});
      take_rsp(0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int saved_rsp;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_adr_i   = 32'h0;
    bus.req_dat_i   = 32'h0;
    bus.req_sel_i   = 4'h0;
    bus.rsp_ready_i = 1'b0;
    bus.ack_i       = 1'b0;
    bus.err_i       = 1'b0;
    bus.dat_i       = 32'h0;

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    idle(2);
    check("reset_req_ready", bus.req_ready_o, 1'b1);
    check("reset_cyc", bus.cyc_o, 1'b0);
    check("reset_rsp_valid", bus.rsp_valid_o, 1'b0);
    rst = 1'b0;
    idle(1);

    // Write, acked in first BUS cycle.
    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h5555_AAAA);
    idle(1);
    check("wr_cyc_len", last_cyc_len, 1);
    check("wr_we", last_we, 1'b1);
    check("wr_adr", last_adr, 32'h3000_0004);
    check("wr_dat", last_dat, 32'hDEAD_BEEF);
    check("wr_sel", last_sel, 4'hF);
    check("wr_rsp_dat", last_rsp_dat, 32'h0);
    check("wr_rsp_err", last_rsp_err, 1'b0);

    // Read with three wait states.
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 0, 0, 32'h1234_5678);
    idle(1);
    check("rd_cyc_len", last_cyc_len, 4);
    check("rd_rsp_dat", last_rsp_dat, 32'h1234_5678);
    check("rd_rsp_err", last_rsp_err, 1'b0);

    // ack and err on the same edge.
    run_txn(1'b0, 32'h3000_0014, 32'h0, 4'h3, 1, 2, 0, 32'hFFFF_FFFF);
    idle(1);
    check("errprio_rsp_err", last_rsp_err, 1'b1);
    check("errprio_rsp_dat", last_rsp_dat, 32'h0);

    // Response held off for five cycles.
    run_txn(1'b0, 32'h3000_0018, 32'h0, 4'hF, 0, 0, 5, 32'hA5A5_0F0F);
    check("bp_req_ready_after", bus.req_ready_o, 1'b1);
    idle(1);
    check("bp_rsp_len", last_rsp_len, 6);
    check("bp_rsp_dat", last_rsp_dat, 32'hA5A5_0F0F);

    // Unresponsive slave.
    run_hang(32'h3000_001C, 32'hCAFE_F00D);

    // Reset during the second BUS cycle.
    saved_rsp = rsp_count;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    idle(1);
    rst = 1'b1;
    idle(1);
    check("rst_mid_cyc", bus.cyc_o, 1'b0);
    check("rst_mid_stb", bus.stb_o, 1'b0);
    check("rst_mid_rsp_valid", bus.rsp_valid_o, 1'b0);
    rst       = 1'b0;
    bus.ack_i = 1'b1;
    idle(1);
    bus.ack_i = 1'b0;
    check("rst_mid_req_ready", bus.req_ready_o, 1'b1);
    idle(3);
    check("rst_mid_no_rsp", rsp_count, saved_rsp);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int r;
      int mode;
      r    = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 4), mode, $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    check("sb_drained", exp_q.size(), 0);
    check("rsp_total", rsp_count, 45);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
